decode_hazard_stage: RTL and testbench
======================================

# decode_hazard_stage

Parametrised decode stage for the in-order RISC-V pipeline, sitting between fetch and the ALU stage. It decodes one instruction per cycle and reads the register file through key/value ports. It tracks the destinations of the last `BYPASS_DEPTH` issued instructions to generate forwarding selects, and inserts a single bubble on a load-use hazard. Valid/ready handshakes on both sides let fetch stall and let execute back-pressure decode.

## Interface
Parameters:
- `XLEN`, 32, datapath width (operands, PC, immediates sign-extended to `XLEN`)
- `REG_ADDR_W`, 5, register key width
- `BYPASS_DEPTH`, 2, downstream stages tracked for forwarding (1 = ALU, 2 = MEM, ...); range 1..7
- `BYP_W`, derived `$clog2(BYPASS_DEPTH+1)`, bypass select width

Ports:
- `clk` in 1, single clock
- `reset` in 1, synchronous, active-high
- `in_valid` in 1, fetch presents an instruction
- `in_ready` out 1, decode accepts this cycle
- `instruction_register` in 32, raw instruction
- `current_program_counter` in XLEN, PC of the instruction
- `in_passthrough_next_program_counter` in XLEN, PC+4 from fetch
- `kill_instr` in 1, squash the presented instruction
- `source1_register_key`, `source2_register_key` out REG_ADDR_W, combinational rs1/rs2
- `source1_register_value`, `source2_register_value` in XLEN, regfile read data, same cycle
- `out_valid` out 1, output register holds a real instruction
- `out_ready` in 1, execute accepts
- `operand1`, `operand2` out XLEN
- `alu_operation` out 5
- `bypass1`, `bypass2` out BYP_W, 0 = none, k = forward from stage k
- `dest_register_enable` out 1; `dest_register_number` out REG_ADDR_W
- `is_load` out 1
- `branch_dest` out XLEN
- `out_passthrough_next_program_counter` out XLEN
- `stall_count` out 32, load-use bubbles inserted, saturating

## Operation
- Decode: OP, OP_IMM, LOAD, STORE, BRANCH, JALR, JAL, LUI.
  - operand2: OP/BRANCH use rs2 value; OP_IMM/LOAD use immI; STORE uses immS; JALR uses immI with bit0 cleared; LUI uses immU; JAL uses 0.
  - operand1: rs1 value; LUI forces 0.
- ALU op: ADD/ADDI → ADDITION; SUB (f7=0x20) → SUBTRACTION; MUL (f7=0x01) → MULTIPLICATION; JALR/JAL → UNCOND_JUMP; BEQ → COND_EQ_JUMP; BNE → COND_NE_JUMP; otherwise ADDITION.
- Destination enable is set for OP, OP_IMM, LOAD, JALR, JAL and LUI, and cleared otherwise. rd = x0 always clears the enable.
- `branch_dest`: PC + sext(immB) for BRANCH, PC + sext(immJ) for JAL, XLEN-bit wrap-around.
- History: shift register of `BYPASS_DEPTH` entries {valid, rd, load}.
  - Entry 1 is the instruction in the output register.
  - Shifts by one whenever the output register is overwritten: an accept or a bubble.
  - Holds when `out_valid && !out_ready`.
- Bypass: for each source, select the lowest k with valid, dest enabled and rd matching. rs = x0 never bypasses. Sources unused by the opcode give 0.
- Load-use hazard: entry 1 is a load and its rd matches a used rs of the presented valid instruction.
  - `in_ready` = 0; one bubble is written (`out_valid` = 0, history entry invalid); `stall_count` += 1.
  - Next cycle the same instruction is re-decoded with bypass from stage 2. This requires `BYPASS_DEPTH` ≥ 2; with depth 1 the stall lasts until the load leaves the history.
- `kill_instr` with `in_valid`: the instruction is consumed (`in_ready` = 1), a bubble is written, and no history entry is made. Kill has priority over the hazard stall.
- `in_ready` = (`!out_valid` || `out_ready`) && !hazard, or the kill case above.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Keys are combinational from `instruction_register`; register values are sampled at the same edge.
- Reset (synchronous), all outputs:
  - `out_valid` = 0; operands, `branch_dest`, passthrough PC = 0.
  - `alu_operation` = ADDITION; dest enable = 0, number = x0.
  - bypasses = 0; `is_load` = 0; `stall_count` = 0; history cleared.
- Reset mid-stall drops the held instruction; fetch re-presents it.
- Back-pressure with a hazard present: no bubble and no count; the output holds.
- `stall_count` saturates at 0xFFFFFFFF.

## Structure
- Opcodes, funct codes, ALU op codes (including new COND_NE_JUMP), NO_BYPASS = 0, NOP, x0, TRUE/FALSE go in the shared constants package.
- One natural sub-module: `bypass_scoreboard` (history shift register plus priority match for both sources and the load-use flag).

## Test plan
- `add x3,x1,x2` (regfile 5, 7) accepted, `out_ready`=1 → next cycle `out_valid`=1, operand1=5, operand2=7, ADDITION, dest x3, bypass 0/0.
- `addi x4,x0,1` then `add x5,x4,x4` back-to-back → second output has bypass1=bypass2=1. One unrelated instruction in between → both =2.
- `lw x6,0(x1)` then `add x7,x6,x2` → one bubble, `in_ready` low for 1 cycle, `stall_count`=1, then add issues with bypass1=2.
- `out_ready`=0 for 3 cycles with valid output → outputs and history frozen, `in_ready`=0, no count change.
- `kill_instr`=1 on `lw` following a load hazard → bubble, no history entry, no stall.
- `beq` at PC 0x100, offset −8 → `branch_dest`=0xF8, COND_EQ_JUMP, dest enable 0. `addi x0,x0,5` → dest enable 0, never bypassed.

Source files
------------

// File: rtl/decode_hazard_stage_pkg.sv
// rtl/decode_hazard_stage_pkg.sv - shared constants for the decode/hazard stage
// Purpose: RV32 opcodes, funct codes, ALU operation codes and common literals.
// Ports: none (package).
package decode_hazard_stage_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_SUB     = 7'h20;
  localparam logic [6:0] F7_MULDIV  = 7'h01;

  localparam int          NO_BYPASS = 0;
  localparam logic [4:0]  X0        = 5'd0;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [4:0] {
    ALU_ADDITION       = 5'd0,
    ALU_SUBTRACTION    = 5'd1,
    ALU_MULTIPLICATION = 5'd2,
    ALU_UNCOND_JUMP    = 5'd3,
    ALU_COND_EQ_JUMP   = 5'd4,
    ALU_COND_NE_JUMP   = 5'd5
  } alu_op_e;

endpackage

// File: rtl/decode_hazard_stage_if.sv
// rtl/decode_hazard_stage_if.sv - fetch/regfile/execute signal bundle for decode
// Purpose: groups the fetch-side handshake, regfile key/value ports and the
// execute-side output register of the decode stage.
// Modports: slave = decode stage view, master = fetch/regfile/execute view.
interface decode_hazard_stage_if #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int BYPASS_DEPTH = 2,
  parameter int BYP_W        = $clog2(BYPASS_DEPTH + 1)
);

  // fetch side
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instruction_register;
  logic [XLEN-1:0]       current_program_counter;
  logic [XLEN-1:0]       in_passthrough_next_program_counter;
  logic                  kill_instr;

  // register file
  logic [REG_ADDR_W-1:0] source1_register_key;
  logic [REG_ADDR_W-1:0] source2_register_key;
  logic [XLEN-1:0]       source1_register_value;
  logic [XLEN-1:0]       source2_register_value;

  // execute side
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       operand1;
  logic [XLEN-1:0]       operand2;
  logic [4:0]            alu_operation;
  logic [BYP_W-1:0]      bypass1;
  logic [BYP_W-1:0]      bypass2;
  logic                  dest_register_enable;
  logic [REG_ADDR_W-1:0] dest_register_number;
  logic                  is_load;
  logic [XLEN-1:0]       branch_dest;
  logic [XLEN-1:0]       out_passthrough_next_program_counter;
  logic [31:0]           stall_count;

  modport slave (
    input  in_valid, instruction_register, current_program_counter,
           in_passthrough_next_program_counter, kill_instr,
           source1_register_value, source2_register_value, out_ready,
    output in_ready, source1_register_key, source2_register_key,
           out_valid, operand1, operand2, alu_operation, bypass1, bypass2,
           dest_register_enable, dest_register_number, is_load, branch_dest,
           out_passthrough_next_program_counter, stall_count
  );

  modport master (
    output in_valid, instruction_register, current_program_counter,
           in_passthrough_next_program_counter, kill_instr,
           source1_register_value, source2_register_value, out_ready,
    input  in_ready, source1_register_key, source2_register_key,
           out_valid, operand1, operand2, alu_operation, bypass1, bypass2,
           dest_register_enable, dest_register_number, is_load, branch_dest,
           out_passthrough_next_program_counter, stall_count
  );

endinterface

// File: rtl/decode_hazard_stage_bypass_scoreboard.sv
// rtl/decode_hazard_stage_bypass_scoreboard.sv - destination history and forwarding match
// Purpose: shift register of the last BYPASS_DEPTH issued destinations plus
// priority match for both sources and the load-use flag.
// Ports: clk/reset; i_shift/i_push_* load a new entry 1; i_rs*/i_use* are the
// presented sources; o_bypass* give the youngest matching stage, o_load_use
// flags a load in entry 1 feeding a used source.
module bypass_scoreboard
  import decode_hazard_stage_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int BYPASS_DEPTH = 2,
  parameter int BYP_W        = $clog2(BYPASS_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_shift,
  input  logic                  i_push_valid,
  input  logic [REG_ADDR_W-1:0] i_push_rd,
  input  logic                  i_push_load,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic                  i_use1,
  input  logic                  i_use2,
  output logic [BYP_W-1:0]      o_bypass1,
  output logic [BYP_W-1:0]      o_bypass2,
  output logic                  o_load_use
);

  // r_valid already folds in "destination enabled", so x0 writers never match.
  logic                  r_valid [BYPASS_DEPTH];
  logic [REG_ADDR_W-1:0] r_rd    [BYPASS_DEPTH];
  logic                  r_load  [BYPASS_DEPTH];

  logic w_src1_live;
  logic w_src2_live;

  assign w_src1_live = i_use1 && (i_rs1 != REG_ADDR_W'(X0));
  assign w_src2_live = i_use2 && (i_rs2 != REG_ADDR_W'(X0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < BYPASS_DEPTH; k++) begin
        r_valid[k] <= FALSE;
        r_rd[k]    <= '0;
        r_load[k]  <= FALSE;
      end
    end else if (i_shift) begin
      r_valid[0] <= i_push_valid;
      r_rd[0]    <= i_push_rd;
      r_load[0]  <= i_push_load;
      for (int k = 1; k < BYPASS_DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_rd[k]    <= r_rd[k-1];
        r_load[k]  <= r_load[k-1];
      end
    end
  end

  // Walk oldest to youngest so the youngest (lowest stage) match wins.
  always_comb begin
    o_bypass1 = BYP_W'(NO_BYPASS);
    o_bypass2 = BYP_W'(NO_BYPASS);
    for (int k = BYPASS_DEPTH - 1; k >= 0; k--) begin
      if (w_src1_live && r_valid[k] && (r_rd[k] == i_rs1)) o_bypass1 = BYP_W'(k + 1);
      if (w_src2_live && r_valid[k] && (r_rd[k] == i_rs2)) o_bypass2 = BYP_W'(k + 1);
    end
  end

  assign o_load_use = r_valid[0] && r_load[0] &&
                      ((w_src1_live && (r_rd[0] == i_rs1)) ||
                       (w_src2_live && (r_rd[0] == i_rs2)));

endmodule

// File: rtl/decode_hazard_stage.sv
// rtl/decode_hazard_stage.sv - RV32 decode stage with forwarding selects and load-use bubble
// Purpose: decodes one instruction per cycle into a registered output, reads the
// regfile combinationally, tracks issued destinations for forwarding and inserts
// one bubble on a load-use hazard.
// Ports: clk, reset (sync, active-high); bus (slave) carries the fetch handshake,
// regfile key/value pairs and the execute-side output register.
module decode_hazard_stage
  import decode_hazard_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int BYPASS_DEPTH = 2,
  parameter int BYP_W        = $clog2(BYPASS_DEPTH + 1)
) (
  input  logic clk,
  input  logic reset,
  decode_hazard_stage_if.slave bus
);

  logic [31:0]           w_ir;
  logic [6:0]            w_opcode;
  logic [2:0]            w_f3;
  logic [6:0]            w_f7;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;

  logic [XLEN-1:0]       w_imm_i;
  logic [XLEN-1:0]       w_imm_s;
  logic [XLEN-1:0]       w_imm_b;
  logic [XLEN-1:0]       w_imm_u;
  logic [XLEN-1:0]       w_imm_j;
  logic signed [31:0]    w_u32;

  logic                  w_use1;
  logic                  w_use2;
  logic [XLEN-1:0]       w_op1;
  logic [XLEN-1:0]       w_op2;
  alu_op_e               w_alu;
  logic                  w_dest_en;
  logic                  w_is_load;
  logic [XLEN-1:0]       w_branch;

  logic [BYP_W-1:0]      w_byp1;
  logic [BYP_W-1:0]      w_byp2;
  logic                  w_load_use;
  logic                  w_can_write;
  logic                  w_kill;
  logic                  w_hazard;
  logic                  w_accept;

  logic                  r_out_valid;
  logic [XLEN-1:0]       r_op1;
  logic [XLEN-1:0]       r_op2;
  alu_op_e               r_alu;
  logic [BYP_W-1:0]      r_byp1;
  logic [BYP_W-1:0]      r_byp2;
  logic                  r_dest_en;
  logic [REG_ADDR_W-1:0] r_dest_num;
  logic                  r_is_load;
  logic [XLEN-1:0]       r_branch;
  logic [XLEN-1:0]       r_npc;
  logic [31:0]           r_stall_count;

  assign w_ir     = bus.instruction_register;
  assign w_opcode = w_ir[6:0];
  assign w_f3     = w_ir[14:12];
  assign w_f7     = w_ir[31:25];
  assign w_rd     = REG_ADDR_W'(w_ir[11:7]);
  assign w_rs1    = REG_ADDR_W'(w_ir[19:15]);
  assign w_rs2    = REG_ADDR_W'(w_ir[24:20]);

  assign w_imm_i = {{(XLEN-12){w_ir[31]}}, w_ir[31:20]};
  assign w_imm_s = {{(XLEN-12){w_ir[31]}}, w_ir[31:25], w_ir[11:7]};
  assign w_imm_b = {{(XLEN-13){w_ir[31]}}, w_ir[31], w_ir[7], w_ir[30:25], w_ir[11:8], 1'b0};
  assign w_u32   = {w_ir[31:12], 12'b0};
  assign w_imm_u = XLEN'(w_u32);
  assign w_imm_j = {{(XLEN-21){w_ir[31]}}, w_ir[31], w_ir[19:12], w_ir[20], w_ir[30:21], 1'b0};

  assign bus.source1_register_key = w_rs1;
  assign bus.source2_register_key = w_rs2;

  always_comb begin
    w_use1    = FALSE;
    w_use2    = FALSE;
    w_op1     = bus.source1_register_value;
    w_op2     = '0;
    w_alu     = ALU_ADDITION;
    w_dest_en = FALSE;
    w_is_load = FALSE;
    w_branch  = '0;
    case (w_opcode)
      OPC_OP: begin
        w_use1    = TRUE;
        w_use2    = TRUE;
        w_op2     = bus.source2_register_value;
        w_dest_en = TRUE;
        if (w_f3 == F3_ADD_SUB && w_f7 == F7_SUB)         w_alu = ALU_SUBTRACTION;
        else if (w_f3 == F3_ADD_SUB && w_f7 == F7_MULDIV) w_alu = ALU_MULTIPLICATION;
      end
      OPC_OP_IMM: begin
        w_use1    = TRUE;
        w_op2     = w_imm_i;
        w_dest_en = TRUE;
      end
      OPC_LOAD: begin
        w_use1    = TRUE;
        w_op2     = w_imm_i;
        w_dest_en = TRUE;
        w_is_load = TRUE;
      end
      OPC_STORE: begin
        w_use1 = TRUE;
        w_use2 = TRUE;
        w_op2  = w_imm_s;
      end
      OPC_BRANCH: begin
        w_use1   = TRUE;
        w_use2   = TRUE;
        w_op2    = bus.source2_register_value;
        w_branch = bus.current_program_counter + w_imm_b;
        if (w_f3 == F3_BEQ)      w_alu = ALU_COND_EQ_JUMP;
        else if (w_f3 == F3_BNE) w_alu = ALU_COND_NE_JUMP;
      end
      OPC_JALR: begin
        w_use1    = TRUE;
        w_op2     = {w_imm_i[XLEN-1:1], 1'b0};
        w_dest_en = TRUE;
        w_alu     = ALU_UNCOND_JUMP;
      end
      OPC_JAL: begin
        w_dest_en = TRUE;
        w_alu     = ALU_UNCOND_JUMP;
        w_branch  = bus.current_program_counter + w_imm_j;
      end
      OPC_LUI: begin
        w_op1     = '0;
        w_op2     = w_imm_u;
        w_dest_en = TRUE;
      end
      default: ;
    endcase
    if (w_rd == REG_ADDR_W'(X0)) w_dest_en = FALSE;
  end

  // The output register (and with it the history) may only be overwritten
  // when it is empty or execute is taking it this cycle.
  assign w_can_write = !r_out_valid || bus.out_ready;
  assign w_kill      = bus.in_valid && bus.kill_instr;
  assign w_hazard    = bus.in_valid && !bus.kill_instr && w_load_use;
  assign w_accept    = w_can_write && bus.in_valid && !bus.kill_instr && !w_load_use;
  assign bus.in_ready = w_can_write && (w_kill || !w_hazard);

  bypass_scoreboard #(
    .REG_ADDR_W   (REG_ADDR_W),
    .BYPASS_DEPTH (BYPASS_DEPTH),
    .BYP_W        (BYP_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .i_shift      (w_can_write),
    .i_push_valid (w_accept && w_dest_en),
    .i_push_rd    (w_rd),
    .i_push_load  (w_is_load),
    .i_rs1        (w_rs1),
    .i_rs2        (w_rs2),
    .i_use1       (w_use1),
    .i_use2       (w_use2),
    .o_bypass1    (w_byp1),
    .o_bypass2    (w_byp2),
    .o_load_use   (w_load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid   <= FALSE;
      r_op1         <= '0;
      r_op2         <= '0;
      r_alu         <= ALU_ADDITION;
      r_byp1        <= BYP_W'(NO_BYPASS);
      r_byp2        <= BYP_W'(NO_BYPASS);
      r_dest_en     <= FALSE;
      r_dest_num    <= REG_ADDR_W'(X0);
      r_is_load     <= FALSE;
      r_branch      <= '0;
      r_npc         <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_can_write) r_out_valid <= w_accept;
      // Payload only moves on a real accept; a bubble just drops out_valid.
      if (w_accept) begin
        r_op1      <= w_op1;
        r_op2      <= w_op2;
        r_alu      <= w_alu;
        r_byp1     <= w_byp1;
        r_byp2     <= w_byp2;
        r_dest_en  <= w_dest_en;
        r_dest_num <= w_rd;
        r_is_load  <= w_is_load;
        r_branch   <= w_branch;
        r_npc      <= bus.in_passthrough_next_program_counter;
      end
      if (w_can_write && w_hazard && (r_stall_count != '1))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.out_valid                            = r_out_valid;
  assign bus.operand1                             = r_op1;
  assign bus.operand2                             = r_op2;
  assign bus.alu_operation                        = r_alu;
  assign bus.bypass1                              = r_byp1;
  assign bus.bypass2                              = r_byp2;
  assign bus.dest_register_enable                 = r_dest_en;
  assign bus.dest_register_number                 = r_dest_num;
  assign bus.is_load                              = r_is_load;
  assign bus.branch_dest                          = r_branch;
  assign bus.out_passthrough_next_program_counter = r_npc;
  assign bus.stall_count                          = r_stall_count;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// tb/tb_decode_hazard_stage.sv - directed self-checking bench for decode_hazard_stage
module tb_decode_hazard_stage;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  decode_hazard_stage_if bus ();

  decode_hazard_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [4:0] k);
    if (k == 5'd0)      return 32'd0;
    else if (k == 5'd1) return 32'd5;
    else if (k == 5'd2) return 32'd7;
    else                return 32'h1000 + {27'd0, k};
  endfunction

  always_comb begin
    bus.source1_register_value = rf_val(bus.source1_register_key);
    bus.source2_register_value = rf_val(bus.source2_register_key);
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, 3'b010 & {3{op == 7'h03}}, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc, input logic kill);
    bus.in_valid                            = 1'b1;
    bus.kill_instr                          = kill;
    bus.instruction_register                = instr;
    bus.current_program_counter             = pc;
    bus.in_passthrough_next_program_counter = pc + 32'd4;
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    present(instr, pc, 1'b0);
    tick();
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.kill_instr = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                                   = 1'b1;
    bus.in_valid                            = 1'b0;
    bus.kill_instr                          = 1'b0;
    bus.out_ready                           = 1'b1;
    bus.instruction_register                = 32'h0000_0013;
    bus.current_program_counter             = '0;
    bus.in_passthrough_next_program_counter = '0;
    repeat (2) tick();

    // reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_operand1", bus.operand1, 0);
    check("rst_operand2", bus.operand2, 0);
    check("rst_alu", bus.alu_operation, 0);
    check("rst_dest_en", bus.dest_register_enable, 0);
    check("rst_dest_num", bus.dest_register_number, 0);
    check("rst_bypass1", bus.bypass1, 0);
    check("rst_bypass2", bus.bypass2, 0);
    check("rst_is_load", bus.is_load, 0);
    check("rst_branch", bus.branch_dest, 0);
    check("rst_npc", bus.out_passthrough_next_program_counter, 0);
    check("rst_stall", bus.stall_count, 0);
    reset = 1'b0;

    // add x3,x1,x2
    present(enc_r(7'h00, 5'd2, 5'd1, 5'd3), 32'h40, 1'b0);
    check("add_in_ready", bus.in_ready, 1);
    tick();
    check("add_valid", bus.out_valid, 1);
    check("add_op1", bus.operand1, 5);
    check("add_op2", bus.operand2, 7);
    check("add_alu", bus.alu_operation, 0);
    check("add_dest_en", bus.dest_register_enable, 1);
    check("add_dest", bus.dest_register_number, 3);
    check("add_byp1", bus.bypass1, 0);
    check("add_byp2", bus.bypass2, 0);
    check("add_npc", bus.out_passthrough_next_program_counter, 32'h44);
    idle();

    // sub / mul alu codes
    issue(enc_r(7'h20, 5'd2, 5'd1, 5'd3), 32'h48);
    check("sub_alu", bus.alu_operation, 1);
    issue(enc_r(7'h01, 5'd2, 5'd1, 5'd3), 32'h4C);
    check("mul_alu", bus.alu_operation, 2);
    idle();

    // addi x4,x0,1 ; add x5,x4,x4 back-to-back
    issue(enc_i(12'd1, 5'd0, 5'd4, 7'h13), 32'h50);
    check("addi_op1", bus.operand1, 0);
    check("addi_op2", bus.operand2, 1);
    check("addi_dest", bus.dest_register_number, 4);
    issue(enc_r(7'h00, 5'd4, 5'd4, 5'd5), 32'h54);
    check("b2b_byp1", bus.bypass1, 1);
    check("b2b_byp2", bus.bypass2, 1);
    idle();

    // one unrelated instruction in between
    issue(enc_i(12'd1, 5'd0, 5'd4, 7'h13), 32'h60);
    issue(enc_i(12'd2, 5'd0, 5'd9, 7'h13), 32'h64);
    issue(enc_r(7'h00, 5'd4, 5'd4, 5'd5), 32'h68);
    check("gap_byp1", bus.bypass1, 2);
    check("gap_byp2", bus.bypass2, 2);
    idle();

    // lw x6,0(x1) ; add x7,x6,x2 -> one bubble
    issue(enc_i(12'd0, 5'd1, 5'd6, 7'h03), 32'h70);
    check("lw_is_load", bus.is_load, 1);
    check("lw_op1", bus.operand1, 5);
    present(enc_r(7'h00, 5'd2, 5'd6, 5'd7), 32'h74, 1'b0);
    check("lu_in_ready_lo", bus.in_ready, 0);
    tick();
    check("lu_bubble", bus.out_valid, 0);
    check("lu_stall", bus.stall_count, 1);
    check("lu_in_ready_hi", bus.in_ready, 1);
    tick();
    check("lu_valid", bus.out_valid, 1);
    check("lu_dest", bus.dest_register_number, 7);
    check("lu_byp1", bus.bypass1, 2);
    check("lu_byp2", bus.bypass2, 0);
    idle();

    // back-pressure with a load-use hazard pending
    issue(enc_i(12'd0, 5'd1, 5'd11, 7'h03), 32'h80);
    bus.out_ready = 1'b0;
    present(enc_r(7'h00, 5'd0, 5'd11, 5'd12), 32'h84, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", bus.in_ready, 0);
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_dest", bus.dest_register_number, 11);
      check("bp_stall", bus.stall_count, 1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_hazard_ready", bus.in_ready, 0);
    tick();
    check("bp_bubble", bus.out_valid, 0);
    check("bp_stall2", bus.stall_count, 2);
    tick();
    check("bp_issue", bus.out_valid, 1);
    check("bp_byp1", bus.bypass1, 2);
    idle();

    // kill on a load that would hit a load-use hazard
    issue(enc_i(12'd0, 5'd1, 5'd13, 7'h03), 32'h90);
    present(enc_i(12'd0, 5'd13, 5'd14, 7'h03), 32'h94, 1'b1);
    check("kill_in_ready", bus.in_ready, 1);
    tick();
    check("kill_bubble", bus.out_valid, 0);
    check("kill_stall", bus.stall_count, 2);
    present(enc_r(7'h00, 5'd13, 5'd14, 5'd15), 32'h98, 1'b0);
    check("kill_next_ready", bus.in_ready, 1);
    tick();
    check("kill_next_valid", bus.out_valid, 1);
    check("kill_next_byp1", bus.bypass1, 0);
    check("kill_next_byp2", bus.bypass2, 2);
    idle();

    // branches, jumps, lui, x0 destination
    issue(enc_b(-13'sd8, 5'd2, 5'd1, 3'b000), 32'h100);
    check("beq_dest", bus.branch_dest, 32'hF8);
    check("beq_alu", bus.alu_operation, 4);
    check("beq_dest_en", bus.dest_register_enable, 0);
    check("beq_op2", bus.operand2, 7);
    issue(enc_b(13'd12, 5'd2, 5'd1, 3'b001), 32'h100);
    check("bne_dest", bus.branch_dest, 32'h10C);
    check("bne_alu", bus.alu_operation, 5);
    issue(enc_j(21'd16, 5'd1), 32'h200);
    check("jal_dest", bus.branch_dest, 32'h210);
    check("jal_alu", bus.alu_operation, 3);
    check("jal_op2", bus.operand2, 0);
    check("jal_dest_en", bus.dest_register_enable, 1);
    issue({20'h12345, 5'd5, 7'h37}, 32'h204);
    check("lui_op1", bus.operand1, 0);
    check("lui_op2", bus.operand2, 32'h1234_5000);
    issue(enc_i(12'd5, 5'd0, 5'd0, 7'h13), 32'h208);
    check("x0_dest_en", bus.dest_register_enable, 0);
    check("x0_op2", bus.operand2, 5);
    issue(enc_r(7'h00, 5'd0, 5'd0, 5'd18), 32'h20C);
    check("x0_byp1", bus.bypass1, 0);
    check("x0_byp2", bus.bypass2, 0);
    idle();

    // reset in the middle of a load-use stall
    issue(enc_i(12'd0, 5'd1, 5'd20, 7'h03), 32'h300);
    present(enc_r(7'h00, 5'd0, 5'd20, 5'd21), 32'h304, 1'b0);
    check("rs_hazard", bus.in_ready, 0);
    reset = 1'b1;
    tick();
    check("rs_valid", bus.out_valid, 0);
    check("rs_stall", bus.stall_count, 0);
    reset = 1'b0;
    #1;
    check("rs_ready", bus.in_ready, 1);
    tick();
    check("rs_issue", bus.out_valid, 1);
    check("rs_byp1", bus.bypass1, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
